// File: rtl/acc_pkg.sv
// Shared opcode encoding and default sizes for the accumulator datapath.
package acc_pkg;

    localparam int unsigned OP_W            = 4;
    localparam int unsigned DEF_WIDTH       = 16;
    localparam int unsigned DEF_STACK_DEPTH = 4;

    typedef enum logic [OP_W-1:0] {
        OP_NOP    = 4'd0,
        OP_LOAD   = 4'd1,
        OP_CLR    = 4'd2,
        OP_ADD    = 4'd3,
        OP_SUB    = 4'd4,
        OP_AND    = 4'd5,
        OP_OR     = 4'd6,
        OP_XOR    = 4'd7,
        OP_SHL    = 4'd8,
        OP_SHR    = 4'd9,
        OP_PUSH   = 4'd10,
        OP_POP    = 4'd11,
        OP_RSV12  = 4'd12,
        OP_RSV13  = 4'd13,
        OP_RSV14  = 4'd14,
        OP_RSV15  = 4'd15
    } op_t;

endpackage

// File: rtl/acc_lifo.sv
// Register-array LIFO holding saved accumulator values; owns the full/empty bounds.
module acc_lifo
    import acc_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_STACK_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_c,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             full_q;
    logic             empty_q;
    logic             push_ok;
    logic             pop_ok;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;

    // Requests past the boundaries are ignored here, so the pointer never wraps.
    assign push_ok = push_i && !full_q;
    assign pop_ok  = pop_i && !empty_q;
    assign wr_idx  = AW'(cnt_q);
    assign rd_idx  = AW'(cnt_q - CW'(1));
    assign data_c  = mem_q[rd_idx];
    assign full_o  = full_q;
    assign empty_o = empty_q;

    // Next entry count.
    always_comb begin
        cnt_d = cnt_q;
        if (push_ok) begin
            cnt_d = cnt_q + CW'(1);
        end else if (pop_ok) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Count and registered boundary flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == CW'(DEPTH));
            empty_q <= (cnt_d == '0);
        end
    end

    // Entry storage; contents are meaningless after reset so no reset here.
    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            mem_q[wr_idx] <= data_i;
        end
    end

endmodule

// File: rtl/acc_alu_reg.sv
// Accumulator register with ALU ops, NZCV flags, save/restore stack and error pulse.
module acc_alu_reg
    import acc_pkg::*;
#(
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned STACK_DEPTH = DEF_STACK_DEPTH,
    parameter int unsigned SATURATE    = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] acc,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic             stack_full,
    output logic             stack_empty,
    output logic             err
);

    localparam int unsigned MSB = WIDTH - 1;
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    op_t              op_e;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             z_q, z_d;
    logic             n_q, n_d;
    logic             c_q, c_d;
    logic             v_q, v_d;
    logic             err_q, err_d;
    logic             wr_acc;
    logic             push_c;
    logic             pop_c;
    logic [WIDTH-1:0] stk_top_c;
    logic             stk_full;
    logic             stk_empty;
    logic [WIDTH:0]   sum_c;
    logic [WIDTH:0]   dif_c;

    assign op_e  = op_t'(op);
    assign sum_c = {1'b0, acc_q} + {1'b0, in};
    assign dif_c = {1'b0, acc_q} - {1'b0, in};

    acc_lifo #(
        .WIDTH (WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_lifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_c),
        .pop_i   (pop_c),
        .data_i  (acc_q),
        .data_c  (stk_top_c),
        .full_o  (stk_full),
        .empty_o (stk_empty)
    );

    // Opcode decode, ALU result, flag next-state and error detection.
    always_comb begin
        acc_d  = acc_q;
        z_d    = z_q;
        n_d    = n_q;
        c_d    = c_q;
        v_d    = v_q;
        err_d  = 1'b0;
        wr_acc = 1'b0;
        push_c = 1'b0;
        pop_c  = 1'b0;
        if (en) begin
            case (op_e)
                OP_NOP: begin
                end
                OP_LOAD: begin
                    acc_d  = in;
                    c_d    = 1'b0;
                    v_d    = 1'b0;
                    wr_acc = 1'b1;
                end
                OP_CLR: begin
                    acc_d  = '0;
                    c_d    = 1'b0;
                    v_d    = 1'b0;
                    wr_acc = 1'b1;
                end
                OP_ADD: begin
                    c_d    = sum_c[WIDTH];
                    v_d    = (acc_q[MSB] == in[MSB]) && (sum_c[MSB] != acc_q[MSB]);
                    acc_d  = sum_c[WIDTH-1:0];
                    // On overflow the true result has the sign of acc.
                    if ((SATURATE != 0) && v_d) begin
                        acc_d = acc_q[MSB] ? SMIN : SMAX;
                    end
                    wr_acc = 1'b1;
                end
                OP_SUB: begin
                    c_d    = dif_c[WIDTH];
                    v_d    = (acc_q[MSB] != in[MSB]) && (dif_c[MSB] != acc_q[MSB]);
                    acc_d  = dif_c[WIDTH-1:0];
                    if ((SATURATE != 0) && v_d) begin
                        acc_d = acc_q[MSB] ? SMIN : SMAX;
                    end
                    wr_acc = 1'b1;
                end
                OP_AND: begin
                    acc_d  = acc_q & in;
                    wr_acc = 1'b1;
                end
                OP_OR: begin
                    acc_d  = acc_q | in;
                    wr_acc = 1'b1;
                end
                OP_XOR: begin
                    acc_d  = acc_q ^ in;
                    wr_acc = 1'b1;
                end
                OP_SHL: begin
                    acc_d  = {acc_q[WIDTH-2:0], 1'b0};
                    c_d    = acc_q[MSB];
                    v_d    = acc_q[MSB] ^ acc_q[WIDTH-2];
                    wr_acc = 1'b1;
                end
                OP_SHR: begin
                    acc_d  = {1'b0, acc_q[WIDTH-1:1]};
                    c_d    = acc_q[0];
                    v_d    = 1'b0;
                    wr_acc = 1'b1;
                end
                OP_PUSH: begin
                    if (stk_full) begin
                        err_d = 1'b1;
                    end else begin
                        push_c = 1'b1;
                    end
                end
                OP_POP: begin
                    if (stk_empty) begin
                        err_d = 1'b1;
                    end else begin
                        pop_c  = 1'b1;
                        acc_d  = stk_top_c;
                        wr_acc = 1'b1;
                    end
                end
                default: begin
                    err_d = 1'b1;
                end
            endcase
        end
        if (wr_acc) begin
            z_d = (acc_d == '0);
            n_d = acc_d[MSB];
        end
    end

    // Accumulator, flag and error registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
            z_q   <= 1'b1;
            n_q   <= 1'b0;
            c_q   <= 1'b0;
            v_q   <= 1'b0;
            err_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            z_q   <= z_d;
            n_q   <= n_d;
            c_q   <= c_d;
            v_q   <= v_d;
            err_q <= err_d;
        end
    end

    assign acc         = acc_q;
    assign flag_z      = z_q;
    assign flag_n      = n_q;
    assign flag_c      = c_q;
    assign flag_v      = v_q;
    assign err         = err_q;
    assign stack_full  = stk_full;
    assign stack_empty = stk_empty;

endmodule

// File: tb/tb_acc_alu_reg.sv
// Bench: wrapping and saturating instances driven in lockstep against an arithmetic model.
module tb_acc_alu_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [3:0]  op;
    logic [15:0] in;

    logic [15:0] a0, a1;
    logic        z0, n0, c0, v0, f0, e0, r0;
    logic        z1, n1, c1, v1, f1, e1, r1;

    int n_cmp = 0;
    int n_err = 0;

    // Model state, index 0 = wrapping, 1 = saturating.
    logic [15:0] m_acc [2];
    logic        m_z [2], m_n [2], m_c [2], m_v [2], m_err [2];
    logic [15:0] stk0 [$];
    logic [15:0] stk1 [$];

    always #5 clk = ~clk;

    acc_alu_reg #(.WIDTH(16), .STACK_DEPTH(4), .SATURATE(0)) u_dut0 (
        .clk(clk), .reset(reset), .en(en), .op(op), .in(in),
        .acc(a0), .flag_z(z0), .flag_n(n0), .flag_c(c0), .flag_v(v0),
        .stack_full(f0), .stack_empty(e0), .err(r0)
    );

    acc_alu_reg #(.WIDTH(16), .STACK_DEPTH(4), .SATURATE(1)) u_dut1 (
        .clk(clk), .reset(reset), .en(en), .op(op), .in(in),
        .acc(a1), .flag_z(z1), .flag_n(n1), .flag_c(c1), .flag_v(v1),
        .stack_full(f1), .stack_empty(e1), .err(r1)
    );

    function automatic int sx(input logic [15:0] x);
        return x[15] ? int'(x) - 65536 : int'(x);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_acc[k] = 16'h0; m_z[k] = 1'b1; m_n[k] = 1'b0;
            m_c[k] = 1'b0; m_v[k] = 1'b0; m_err[k] = 1'b0;
        end
        stk0.delete();
        stk1.delete();
    endtask

    task automatic model_step(input int k, input logic e, input logic [3:0] o, input logic [15:0] d);
        logic [15:0] a;
        logic [15:0] st [$];
        logic        wr;
        int          s;
        a  = m_acc[k];
        wr = 1'b0;
        m_err[k] = 1'b0;
        if (k == 0) st = stk0; else st = stk1;
        if (e) begin
            case (o)
                4'd0: ;
                4'd1: begin m_acc[k] = d; m_c[k] = 1'b0; m_v[k] = 1'b0; wr = 1'b1; end
                4'd2: begin m_acc[k] = 16'h0; m_c[k] = 1'b0; m_v[k] = 1'b0; wr = 1'b1; end
                4'd3: begin
                    m_c[k] = (int'(a) + int'(d)) > 65535;
                    s = sx(a) + sx(d);
                    m_v[k] = (s > 32767) || (s < -32768);
                    m_acc[k] = 16'(int'(a) + int'(d));
                    if (k == 1 && m_v[k]) m_acc[k] = (s > 0) ? 16'h7FFF : 16'h8000;
                    wr = 1'b1;
                end
                4'd4: begin
                    m_c[k] = a < d;
                    s = sx(a) - sx(d);
                    m_v[k] = (s > 32767) || (s < -32768);
                    m_acc[k] = 16'(int'(a) - int'(d));
                    if (k == 1 && m_v[k]) m_acc[k] = (s > 0) ? 16'h7FFF : 16'h8000;
                    wr = 1'b1;
                end
                4'd5: begin m_acc[k] = a & d; wr = 1'b1; end
                4'd6: begin m_acc[k] = a | d; wr = 1'b1; end
                4'd7: begin m_acc[k] = a ^ d; wr = 1'b1; end
                4'd8: begin
                    m_c[k] = a >= 16'h8000;
                    m_v[k] = ((a >> 15) & 16'h1) != ((a >> 14) & 16'h1);
                    m_acc[k] = 16'(int'(a) * 2);
                    wr = 1'b1;
                end
                4'd9: begin
                    m_c[k] = (a % 16'd2) == 16'd1;
                    m_v[k] = 1'b0;
                    m_acc[k] = a / 16'd2;
                    wr = 1'b1;
                end
                4'd10: begin
                    if (st.size() == 4) m_err[k] = 1'b1;
                    else st.push_back(a);
                end
                4'd11: begin
                    if (st.size() == 0) m_err[k] = 1'b1;
                    else begin m_acc[k] = st.pop_back(); wr = 1'b1; end
                end
                default: m_err[k] = 1'b1;
            endcase
        end
        if (wr) begin
            m_z[k] = (m_acc[k] == 16'h0);
            m_n[k] = (m_acc[k] >= 16'h8000);
        end
        if (k == 0) stk0 = st; else stk1 = st;
    endtask

    task automatic check_all(input string tag);
        logic [15:0] oa;
        logic        oz, on, oc, ov, of, oe, orr;
        int          sz;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                oa = a0; oz = z0; on = n0; oc = c0; ov = v0; of = f0; oe = e0; orr = r0; sz = stk0.size();
            end else begin
                oa = a1; oz = z1; on = n1; oc = c1; ov = v1; of = f1; oe = e1; orr = r1; sz = stk1.size();
            end
            chk($sformatf("%s d%0d acc", tag, k), 32'(oa), 32'(m_acc[k]));
            chk($sformatf("%s d%0d z", tag, k), 32'(oz), 32'(m_z[k]));
            chk($sformatf("%s d%0d n", tag, k), 32'(on), 32'(m_n[k]));
            chk($sformatf("%s d%0d c", tag, k), 32'(oc), 32'(m_c[k]));
            chk($sformatf("%s d%0d v", tag, k), 32'(ov), 32'(m_v[k]));
            chk($sformatf("%s d%0d full", tag, k), 32'(of), 32'(sz == 4));
            chk($sformatf("%s d%0d empty", tag, k), 32'(oe), 32'(sz == 0));
            chk($sformatf("%s d%0d err", tag, k), 32'(orr), 32'(m_err[k]));
        end
    endtask

    task automatic cycle(input string tag, input logic e, input logic [3:0] o, input logic [15:0] d);
        @(negedge clk);
        reset = 1'b0; en = e; op = o; in = d;
        @(posedge clk);
        model_step(0, e, o, d);
        model_step(1, e, o, d);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        en = 1'b1;
        op = 4'($urandom_range(0, 15));
        in = 16'($urandom);
        @(posedge clk);
        model_reset();
        #1;
        check_all(tag);
        @(negedge clk);
        reset = 1'b0;
        en = 1'b0;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; op = 4'd0; in = 16'h0;
        model_reset();
        do_reset("reset");

        // Basic arithmetic and clear.
        cycle("load5", 1'b1, 4'd1, 16'h0005);
        cycle("add3", 1'b1, 4'd3, 16'h0003);
        chk("plan add acc", 32'(a0), 32'h0008);
        cycle("clr", 1'b1, 4'd2, 16'h1234);
        chk("plan clr z", 32'(z0), 32'h1);

        // Signed overflow, wrapping vs. saturating.
        cycle("load7fff", 1'b1, 4'd1, 16'h7FFF);
        cycle("addovf", 1'b1, 4'd3, 16'h0001);
        chk("plan wrap acc", 32'(a0), 32'h8000);
        chk("plan sat acc", 32'(a1), 32'h7FFF);
        chk("plan sat v", 32'(v1), 32'h1);

        // Borrow and shift-left flags.
        cycle("load0", 1'b1, 4'd1, 16'h0000);
        cycle("sub1", 1'b1, 4'd4, 16'h0001);
        chk("plan sub acc", 32'(a0), 32'hFFFF);
        cycle("load8001", 1'b1, 4'd1, 16'h8001);
        cycle("shl", 1'b1, 4'd8, 16'h0000);
        chk("plan shl acc", 32'(a0), 32'h0002);
        cycle("shr", 1'b1, 4'd9, 16'h0000);

        // Fill the stack, overflow it, drain it, underflow it.
        for (int i = 1; i <= 4; i++) begin
            cycle("fill load", 1'b1, 4'd1, 16'(i));
            cycle("fill push", 1'b1, 4'd10, 16'h0);
        end
        chk("plan full", 32'(f0), 32'h1);
        cycle("push full", 1'b1, 4'd10, 16'h0);
        chk("plan push err", 32'(r0), 32'h1);
        for (int i = 4; i >= 1; i--) begin
            cycle("drain pop", 1'b1, 4'd11, 16'h0);
            chk("plan pop acc", 32'(a0), 32'(i));
        end
        cycle("pop empty", 1'b1, 4'd11, 16'h0);
        chk("plan pop err", 32'(r0), 32'h1);
        chk("plan pop err acc", 32'(a0), 32'h1);

        // Hold with en low, then a reserved opcode.
        for (int i = 0; i < 3; i++) cycle("hold", 1'b0, 4'd3, 16'h0101);
        cycle("rsv13", 1'b1, 4'd13, 16'hFFFF);
        cycle("after rsv", 1'b1, 4'd0, 16'h0);

        // Reset mid-sequence discards stacked values.
        cycle("pre push a", 1'b1, 4'd10, 16'h0);
        cycle("pre push b", 1'b1, 4'd10, 16'h0);
        do_reset("mid reset");
        cycle("pop after reset", 1'b1, 4'd11, 16'h0);
        chk("plan reset pop err", 32'(r0), 32'h1);
        chk("plan reset acc", 32'(a0), 32'h0);

        // Randomized traffic with occasional resets and idle cycles.
        for (int i = 0; i < 600; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                do_reset("rnd reset");
            end else begin
                logic [15:0] d;
                case ($urandom_range(0, 3))
                    0: d = 16'h7FFF;
                    1: d = 16'h8000;
                    default: d = 16'($urandom);
                endcase
                cycle("rnd", r >= 10, 4'($urandom_range(0, 15)), d);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/acc_alu_reg.md
# acc_alu_reg

Parametrised accumulator register with integrated ALU operations, status flags and a small LIFO save/restore stack, replacing the plain 16-bit load-only accumulator in the processor datapath. It sits between the operand bus and the writeback path. Each enabled cycle it executes one opcode against the current accumulator and the input operand, and registers the result and flags.

## Interface
- `WIDTH`, 16: accumulator and operand width in bits; must be at least 2.
- `STACK_DEPTH`, 4: number of save/restore stack entries; must be at least 1.
- `SATURATE`, 0: when 1, signed ADD/SUB overflow clamps to the signed max/min instead of wrapping.

Ports:
- `clk`, input, 1: clock; all state changes on the rising edge.
- `reset`, input, 1: reset, synchronous, active-high.
- `en`, input, 1: execute `op` this cycle; when 0, all state holds.
- `op`, input, 4: opcode (see Operation).
- `in`, input, WIDTH: operand.
- `acc`, output, WIDTH: accumulator value.
- `flag_z`, output, 1: acc == 0.
- `flag_n`, output, 1: acc[WIDTH-1].
- `flag_c`, output, 1: carry / borrow / shifted-out bit.
- `flag_v`, output, 1: signed overflow.
- `stack_full`, output, 1: STACK_DEPTH entries held.
- `stack_empty`, output, 1: no entries held.
- `err`, output, 1: one-cycle pulse on an illegal operation.

## Operation
- Opcodes:
  - 0 NOP.
  - 1 LOAD: acc=in.
  - 2 CLR: acc=0.
  - 3 ADD: acc=acc+in.
  - 4 SUB: acc=acc−in.
  - 5 AND, 6 OR, 7 XOR: bitwise with in.
  - 8 SHL: logical left by 1.
  - 9 SHR: logical right by 1.
  - 10 PUSH: push acc onto the stack.
  - 11 POP: pop the stack into acc.
  - 12–15 reserved.
- Arithmetic is computed at WIDTH+1 bits.
  - ADD: C = bit WIDTH of the sum.
  - SUB: C = borrow (1 when acc < in unsigned).
  - V = two's-complement overflow: operands' sign rule for ADD; operands differ in sign and result sign ≠ acc sign for SUB.
- With SATURATE=1 and V=1: acc = 0111…1 if the true result is positive, 1000…0 if negative. V is still set; C is unaffected by clamping.
- SHL: C = old acc[WIDTH-1]; V = old acc[WIDTH-1] ^ old acc[WIDTH-2]. SHR: C = old acc[0]; V = 0.
- Flag update rules:
  - Z/N are recomputed on every op that writes acc: LOAD, CLR, ALU, shift, POP.
  - C/V are updated by ADD/SUB/SHL/SHR, cleared by LOAD/CLR, and held by AND/OR/XOR/PUSH/POP/NOP.
- Stack is LIFO, depth STACK_DEPTH. PUSH leaves acc and all flags unchanged. POP writes the top entry to acc and updates Z/N.
- Error cases: err=1 for one cycle, no other state change.
  - PUSH when full.
  - POP when empty.
  - Reserved opcode.
- `en`=0 with any op: nothing changes; err=0.

## Timing
- Single-cycle latency: the op presented with en=1 at edge k is visible on acc and the flags after edge k.
- Back-to-back ops every cycle are supported; each op sees the result of the previous one.
- stack_full and stack_empty are registered and update on the same edge as the PUSH/POP.
- err is registered, high exactly in the cycle following the offending edge.
- Reset values: acc=0, flag_z=1, flag_n=0, flag_c=0, flag_v=0, stack empty (stack_empty=1, stack_full=0), err=0. Stack contents are don't-care.
- Reset wins over en/op on the same edge. Reset asserted mid-sequence discards stack contents.
- No simultaneous push/pop path exists; one op per cycle.

## Structure
- Package `acc_pkg`:
  - `op_t` enum holding the 16 opcode codes.
  - localparams for the opcode width (4) and the default WIDTH/STACK_DEPTH.
- Sub-module `acc_lifo`:
  - parametrised WIDTH/DEPTH register-array stack with pointer, push/pop/data_in/data_out, full/empty.
  - owns the full/empty boundary logic.
- The top level holds the ALU mux, flag registers and err pulse.

## Test plan
- Reset, then LOAD 0x0005, ADD 0x0003 → acc=0x0008, Z=0, C=0, V=0. CLR → acc=0, Z=1, C=0.
- LOAD 0x7FFF, ADD 0x0001:
  - SATURATE=0 → acc=0x8000, N=1, V=1, C=0.
  - SATURATE=1 → acc=0x7FFF, V=1.
- LOAD 0x0000, SUB 0x0001 → acc=0xFFFF, C=1, V=0, N=1. LOAD 0x8001, SHL → acc=0x0002, C=1, V=1.
- STACK_DEPTH=4: LOAD 1..4 each followed by PUSH → stack_full=1. 5th PUSH → err pulse, acc unchanged. Four POPs → acc 4,3,2,1, then stack_empty=1. Another POP → err, acc=1.
- Hold and error behaviour:
  - en=0 with op=ADD for 3 cycles → acc/flags unchanged.
  - op=13 with en=1 → err for one cycle, acc/flags unchanged.
- PUSH twice, assert reset for one cycle, then POP → err (stack empty), acc=0, flag_z=1.
